mem_stage_lsu: RTL and testbench

- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Consumes the registered EX/MEM values: M_alu_out is the effective address, M_rs2_data is the store data.
- Drives a req/ack data-memory port, formats store byte lanes, and extracts and extends load data for the MEM/WB register.
- Raises M_stall while a memory transaction is outstanding.

---
 rtl/mem_stage_lsu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
// Takes the registered EX/MEM values (M_alu_out = effective byte address,
// M_rs2_data = store data), runs one req/ack transaction on the data-memory
// port, formats store byte lanes and sign/zero-extends load data for MEM/WB.
//
// Sequencing: IDLE -> WAIT (request outstanding) -> DONE (pipeline advances)
// -> IDLE. M_stall freezes IF..EX/MEM while a transaction is being launched or
// is outstanding.
//
// Optional feature (macro LSU_TIMEOUT_EN): an 8-bit WAIT-cycle counter aborts
// the transaction after TIMEOUT_CYCLES cycles without ack and flags M_bus_err
// during DONE. Without the macro WAIT lasts until ack and M_bus_err is 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   M_valid           MEM-stage instruction is not a bubble
//   M_mem_read/write  load / store instruction
//   M_funct3          access size and signedness
//   M_alu_out         effective byte address
//   M_rs2_data        store source data
//   M_ld_data         extended load result (registered)
//   M_stall           freeze upstream pipeline registers (combinational)
//   M_fault           misaligned or illegal access (combinational)
//   M_bus_err         timeout abort flag, valid in DONE (registered)
//   dmem_req/we/addr/wstrb/wdata   registered data-memory request
//   dmem_ack, dmem_rdata           memory response, rdata valid with ack
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_valid,
    input  logic        M_mem_read,
    input  logic        M_mem_write,
    input  logic [2:0]  M_funct3,
    input  logic [31:0] M_alu_out,
    input  logic [31:0] M_rs2_data,
    output logic [31:0] M_ld_data,
    output logic        M_stall,
    output logic        M_fault,
    output logic        M_bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;

    logic        is_mem_s;
    logic        misaligned_s;
    logic        illegal_s;
    logic        start_s;
    logic [3:0]  st_wstrb_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_fmt_s;

    // Extract the addressed byte/half from a read word and extend it.
    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b010:  fmt_load = rd;
            3'b100:  fmt_load = {24'h000000, b};
            3'b101:  fmt_load = {16'h0000, h};
            default: fmt_load = rd;
        endcase
    endfunction

    // Byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] fmt_wstrb(input logic [2:0] f3,
                                             input logic [1:0] off);
        case (f3[1:0])
            2'b00:   fmt_wstrb = 4'b0001 << off;
            2'b01:   fmt_wstrb = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   fmt_wstrb = 4'b1111;
            default: fmt_wstrb = 4'b0000;
        endcase
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] fmt_wdata(input logic [2:0]  f3,
                                              input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   fmt_wdata = {4{rs2[7:0]}};
            2'b01:   fmt_wdata = {2{rs2[15:0]}};
            2'b10:   fmt_wdata = rs2;
            default: fmt_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Fault checks only apply to memory instructions; ALU ops reuse funct3
    // and alu_out freely and must not be flagged.
    assign is_mem_s     = M_mem_read | M_mem_write;
    assign misaligned_s = is_mem_s &
                          (((M_funct3[1:0] == 2'b01) & M_alu_out[0]) |
                           ((M_funct3[1:0] == 2'b10) & (M_alu_out[1:0] != 2'b00)));
    assign illegal_s    = is_mem_s &
                          ((M_funct3 == 3'b011) | (M_funct3 == 3'b110) |
                           (M_funct3 == 3'b111) |
                           (M_mem_write & ((M_funct3 == 3'b100) | (M_funct3 == 3'b101))) |
                           (M_mem_read & M_mem_write));
    assign M_fault      = M_valid & (misaligned_s | illegal_s);
    assign start_s      = M_valid & (M_mem_read ^ M_mem_write) & ~M_fault;
    assign M_stall      = ((state_r == S_IDLE) & start_s) | (state_r == S_WAIT);

    assign st_wstrb_s   = M_mem_write ? fmt_wstrb(M_funct3, M_alu_out[1:0]) : 4'b0000;
    assign st_wdata_s   = M_mem_write ? fmt_wdata(M_funct3, M_rs2_data) : 32'h0000_0000;
    assign ld_fmt_s     = fmt_load(funct3_r, offset_r, dmem_rdata);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;

    assign wait_cnt_nxt_s = wait_cnt_r + 8'd1;

    // Transaction sequencer with abort-on-timeout and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            wait_cnt_r <= 8'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_wstrb <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            M_ld_data  <= 32'h0000_0000;
            M_bus_err  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    M_bus_err <= 1'b0;
                    if (start_s) begin
                        funct3_r   <= M_funct3;
                        offset_r   <= M_alu_out[1:0];
                        wait_cnt_r <= 8'd0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= M_mem_write;
                        dmem_addr  <= {M_alu_out[31:2], 2'b00};
                        dmem_wstrb <= st_wstrb_s;
                        dmem_wdata <= st_wdata_s;
                        state_r    <= S_WAIT;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            M_ld_data <= ld_fmt_s;
                        end else begin
                            M_ld_data <= M_ld_data;
                        end
                        dmem_req <= 1'b0;
                        state_r  <= S_DONE;
                    end else if (wait_cnt_nxt_s == TMO_LIMIT) begin
                        // Abort: no data captured, error visible during DONE.
                        dmem_req   <= 1'b0;
                        M_bus_err  <= 1'b1;
                        wait_cnt_r <= wait_cnt_nxt_s;
                        state_r    <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_nxt_s;
                        state_r    <= S_WAIT;
                    end
                end
                S_DONE: begin
                    M_bus_err <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: begin
                    dmem_req  <= 1'b0;
                    M_bus_err <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
`else
    // The timeout limit has no effect in this build.
    logic unused_tmo_s;
    assign unused_tmo_s = ^TMO_LIMIT;
    assign M_bus_err    = 1'b0;

    // Transaction sequencer; WAIT lasts until the memory acknowledges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_wstrb <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            M_ld_data  <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        funct3_r   <= M_funct3;
                        offset_r   <= M_alu_out[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= M_mem_write;
                        dmem_addr  <= {M_alu_out[31:2], 2'b00};
                        dmem_wstrb <= st_wstrb_s;
                        dmem_wdata <= st_wdata_s;
                        state_r    <= S_WAIT;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            M_ld_data <= ld_fmt_s;
                        end else begin
                            M_ld_data <= M_ld_data;
                        end
                        dmem_req <= 1'b0;
                        state_r  <= S_DONE;
                    end else begin
                        state_r  <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    dmem_req <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Scoreboard bench for mem_stage_lsu. The stimulus process issues accesses and
// pushes the expected bus request and load result (from a byte-level reference
// model) into a queue; a monitor pops and compares whenever the memory port
// handshakes. A responder process plays the memory with a per-access latency.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid, M_mem_read, M_mem_write;
    logic [2:0]  M_funct3;
    logic [31:0] M_alu_out, M_rs2_data;
    logic [31:0] M_ld_data;
    logic        M_stall, M_fault, M_bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .M_valid(M_valid), .M_mem_read(M_mem_read), .M_mem_write(M_mem_write),
        .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
        .M_ld_data(M_ld_data), .M_stall(M_stall), .M_fault(M_fault),
        .M_bus_err(M_bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        req_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_n = 1;
    logic [31:0] cur_rdata = 32'h0;
    logic        force_ack = 1'b0;
    logic [31:0] model_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_fault(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = (rd != wr) &&
                ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                 (rd && ((f3 == 3'd4) || (f3 == 3'd5))));
        return !legal || ((a % 4) % acc_size(f3) != 0);
    endfunction

    // Byte-level reference: memory word as four bytes, access of sz bytes at off.
    function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] rdw, input logic [31:0] prev);
        exp_t   e;
        int     sz, off;
        longint v;
        sz      = acc_size(f3);
        off     = int'(a % 4);
        e.addr  = a - (a % 4);
        e.we    = wr;
        e.wstrb = 4'b0000;
        e.wdata = 32'h0;
        e.ld    = prev;
        if (wr) begin
            e.wstrb = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
        end else begin
            v = longint'(rdw >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
            if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            e.ld = v[31:0];
        end
        return e;
    endfunction

    // Memory responder: ack on the n-th cycle the request is seen (n=0: never).
    initial begin
        int wcnt;
        wcnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dmem_rdata = cur_rdata;
            if (dmem_req && !rst) begin
                wcnt++;
                dmem_ack = (wcnt == cur_n);
            end else begin
                wcnt = 0;
                dmem_ack = force_ack;
            end
        end
    end

    // Monitor: compares each handshake and the following DONE cycle.
    initial begin
        exp_t        e;
        logic        pend, prev_req;
        logic [31:0] pend_ld, p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        logic        p_we;
        pend = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (pend) begin
                    chk("done_ld_data", M_ld_data, pend_ld);
                    chk("done_stall", {31'd0, M_stall}, 32'd0);
                    pend = 1'b0;
                end
                if (dmem_req && prev_req) begin
                    chk("hold_addr", dmem_addr, p_addr);
                    chk("hold_wdata", dmem_wdata, p_wdata);
                    chk("hold_wstrb", {28'd0, dmem_wstrb}, {28'd0, p_wstrb});
                    chk("hold_we", {31'd0, dmem_we}, {31'd0, p_we});
                end
                if (dmem_req && dmem_ack) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req addr=%h expected=none", dmem_addr);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_addr", dmem_addr, e.addr);
                        chk("req_we", {31'd0, dmem_we}, {31'd0, e.we});
                        chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, e.wstrb});
                        if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
                        pend = 1'b1;
                        pend_ld = e.ld;
                    end
                end
                prev_req = dmem_req;
                p_addr = dmem_addr;
                p_wdata = dmem_wdata;
                p_wstrb = dmem_wstrb;
                p_we = dmem_we;
            end
        end
    end

    // One access held on the MEM inputs until the stall releases it.
    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rs2, input int n, input logic [31:0] rdw);
        logic flt;
        exp_t e;
        int   cnt, exp_stall;
        @(posedge clk);
        #1;
        M_valid = 1'b1;
        M_mem_read = !wr;
        M_mem_write = wr;
        M_funct3 = f3;
        M_alu_out = a;
        M_rs2_data = rs2;
        cur_n = n;
        cur_rdata = rdw;
        flt = model_fault(!wr, wr, f3, a);
        if (!flt && n != 0) begin
            e = model(wr, f3, a, rs2, rdw, model_ld);
            model_ld = e.ld;
            req_q.push_back(e);
        end
        @(negedge clk);
        #1;
        chk("fault", {31'd0, M_fault}, {31'd0, flt});
        if (flt) begin
            chk("fault_stall", {31'd0, M_stall}, 32'd0);
            @(posedge clk);
            #1;
            M_valid = 1'b0;
            @(negedge clk);
            #1;
            chk("fault_no_req", {31'd0, dmem_req}, 32'd0);
        end else begin
            cnt = 0;
            while (M_stall && cnt < 60) begin
                cnt++;
                @(negedge clk);
                #1;
            end
            exp_stall = (n == 0) ? TMO + 1 : n + 1;
            chk("stall_cycles", cnt, exp_stall);
            if (n == 0) begin
                chk("bus_err_done", {31'd0, M_bus_err}, 32'd1);
                chk("abort_ld_kept", M_ld_data, model_ld);
            end
            @(posedge clk);
            #1;
            M_valid = 1'b0;
            if (n == 0) begin
                @(negedge clk);
                #1;
                chk("bus_err_clear", {31'd0, M_bus_err}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [2:0]  f3_tab [5];
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2;
        f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;

        rst = 1'b1;
        M_valid = 1'b0;
        M_mem_read = 1'b0;
        M_mem_write = 1'b0;
        M_funct3 = 3'd0;
        M_alu_out = 32'h0;
        M_rs2_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ld", M_ld_data, 32'd0);
        chk("rst_bus_err", {31'd0, M_bus_err}, 32'd0);
        chk("rst_stall", {31'd0, M_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        do_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        chk("lb_result", M_ld_data, 32'hFFFF_FF80);
        do_access(1'b0, 3'd5, 32'h0000_0202, 32'h0, 4, 32'hBEEF_0000);
        chk("lhu_result", M_ld_data, 32'h0000_BEEF);
        do_access(1'b1, 3'd0, 32'h0000_0301, 32'hAABB_CCDD, 2, 32'h1111_1111);
        chk("sb_ld_kept", M_ld_data, 32'h0000_BEEF);
        do_access(1'b0, 3'd2, 32'h0000_0402, 32'h0, 1, 32'h0);
        do_access(1'b0, 3'd3, 32'h0000_0400, 32'h0, 1, 32'h0);
        do_access(1'b1, 3'd4, 32'h0000_0400, 32'h0, 1, 32'h0);

        // Reset while a load is outstanding.
        @(posedge clk);
        #1;
        M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
        M_funct3 = 3'd2; M_alu_out = 32'h0000_0500;
        cur_n = 99;
        cur_rdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        #1;
        chk("wait_req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        M_valid = 1'b0;
        #1;
        chk("rst_drop_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_idle_stall", {31'd0, M_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ld = 32'h0;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        force_ack = 1'b0;
        chk("late_ack_ld", M_ld_data, 32'd0);
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);

`ifdef LSU_TIMEOUT_EN
        do_access(1'b0, 3'd2, 32'h0000_0600, 32'h0, 0, 32'h0);
`endif

        // Randomized accesses against the reference model.
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                             : f3_tab[$urandom_range(0, 4)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                                     (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            do_access(wr, f3, a, $urandom, $urandom_range(1, 4), $urandom);
        end

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", req_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
